axis_counter_gen: RTL

Parametrised AXI4-Stream ramp/counter source. It is the successor to the free-running stream counter and adds programmable start, step and limit, a sample-rate prescaler, three waveform modes (sawtooth, triangle, one-shot), run/stop control and correct AXIS back-pressure handling. It feeds test ramps and sweep/address sequences into the downstream DSP and DMA stream chain.

---
 rtl/axis_counter_gen.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_counter_gen.sv
// axis_counter_gen: AXI4-Stream ramp/counter source with programmable start,
// step and limit, a sample-rate prescaler, sawtooth/triangle/one-shot modes,
// run/stop control and back-pressure-safe beat hand-off.
// Optional build macro AXIS_COUNTER_GEN_TLAST_EN adds M_AXIS_tlast, which
// marks the beat after which the sequence restarts.
//
// state  | meaning
// IDLE   | stopped, waiting for run; cfg_* sampled on leaving
// RUN    | prescaling and offering beats
// DONE   | one-shot reached limit; waiting for run to drop
module axis_counter_gen #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_WIDTH    = 32,
    parameter int PRESCALER_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        run,
    input  logic [1:0]                  cfg_mode,
    input  logic [COUNTER_WIDTH-1:0]    cfg_start,
    input  logic [COUNTER_WIDTH-1:0]    cfg_step,
    input  logic [COUNTER_WIDTH-1:0]    cfg_limit,
    input  logic [PRESCALER_WIDTH-1:0]  cfg_prescaler,
    output logic [COUNTER_WIDTH-1:0]    counter,
    output logic                        done,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
`ifdef AXIS_COUNTER_GEN_TLAST_EN
    ,
    output logic                        M_AXIS_tlast
`endif
);

    localparam int CW = COUNTER_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_SAW     = 2'd0;
    localparam logic [1:0] M_TRI     = 2'd1;
    localparam logic [1:0] M_ONESHOT = 2'd2;

    logic [1:0]                 state;
    logic [CW-1:0]              value;
    logic                       dir_down;
    logic [PRESCALER_WIDTH-1:0] pcnt;
    logic                       tvalid;

    logic [1:0]                 sh_mode;
    logic [CW-1:0]              sh_start;
    logic [CW-1:0]              sh_step;
    logic [CW-1:0]              sh_limit;
    logic [PRESCALER_WIDTH-1:0] sh_presc;

    logic [1:0]  mode_eff;
    logic [CW:0] sum;
    logic [CW:0] diff;
    logic        over_limit;
    logic [CW-1:0] up_sat;
    logic [CW-1:0] dn_sat;
    logic [CW-1:0] next_value;
    logic        next_dir_down;
    logic        offer;
    logic        hs;

    // Mode 3 is reserved and behaves as sawtooth
    assign mode_eff = (sh_mode == 2'd3) ? M_SAW : sh_mode;

    // One extra bit on the arithmetic so overflow and borrow are visible
    assign sum        = {1'b0, value} + {1'b0, sh_step};
    assign diff       = {1'b0, value} - {1'b0, sh_step};
    assign over_limit = (sum > {1'b0, sh_limit});
    assign up_sat     = over_limit ? sh_limit : sum[CW-1:0];
    assign dn_sat     = (diff[CW] || (diff[CW-1:0] < sh_start)) ? sh_start : diff[CW-1:0];

    assign offer = (state == S_RUN) && !tvalid && run && (pcnt == '0);
    assign hs    = tvalid && M_AXIS_tready;

    // Value that follows the current beat, per waveform mode
    always_comb begin
        next_value    = value;
        next_dir_down = dir_down;
        case (mode_eff)
            M_TRI: begin
                if (!dir_down) begin
                    if (value == sh_limit) begin
                        next_dir_down = 1'b1;
                        next_value    = dn_sat;
                    end else begin
                        next_value = up_sat;
                    end
                end else begin
                    if (value == sh_start) begin
                        next_dir_down = 1'b0;
                        next_value    = up_sat;
                    end else begin
                        next_value = dn_sat;
                    end
                end
            end
            M_ONESHOT: next_value = up_sat;
            default:   next_value = over_limit ? sh_start : sum[CW-1:0];
        endcase
    end

    // Sequencer: config capture, prescaler, beat hand-off and mode termination
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            value    <= '0;
            dir_down <= 1'b0;
            pcnt     <= '0;
            tvalid   <= 1'b0;
            sh_mode  <= M_SAW;
            sh_start <= '0;
            sh_step  <= '0;
            sh_limit <= '0;
            sh_presc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tvalid <= 1'b0;
                    if (run) begin
                        state    <= S_RUN;
                        sh_mode  <= cfg_mode;
                        sh_start <= cfg_start;
                        sh_step  <= cfg_step;
                        sh_limit <= cfg_limit;
                        sh_presc <= cfg_prescaler;
                        value    <= cfg_start;
                        dir_down <= 1'b0;
                        pcnt     <= cfg_prescaler;
                    end
                end
                S_RUN: begin
                    if (!tvalid) begin
                        if (!run) begin
                            state <= S_IDLE;
                        end else if (pcnt == '0) begin
                            tvalid <= 1'b1;
                        end else begin
                            pcnt <= pcnt - 1'b1;
                        end
                    end else if (M_AXIS_tready) begin
                        tvalid   <= 1'b0;
                        value    <= next_value;
                        dir_down <= next_dir_down;
                        pcnt     <= sh_presc;
                        if (mode_eff == M_ONESHOT && value == sh_limit) begin
                            state <= S_DONE;
                        end else if (!run) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    tvalid <= 1'b0;
                    if (!run) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_COUNTER_GEN_TLAST_EN
    logic last_flag;

    // Beat after which the sequence restarts
    always_comb begin
        case (mode_eff)
            M_TRI:     last_flag = dir_down && (value == sh_start);
            M_ONESHOT: last_flag = (value == sh_limit);
            default:   last_flag = over_limit;
        endcase
    end

    // tlast is captured in the same cycle tvalid rises, so it stays aligned with tdata
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            M_AXIS_tlast <= 1'b0;
        end else if (offer) begin
            M_AXIS_tlast <= last_flag;
        end else if (hs) begin
            M_AXIS_tlast <= 1'b0;
        end
    end
`endif

    assign counter       = value;
    assign done          = (state == S_DONE);
    assign M_AXIS_tvalid = tvalid;
    assign M_AXIS_tdata  = AXIS_TDATA_WIDTH'(value);

endmodule
